// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: word size, FSM state and owner encodings.
package mem_port_arbiter_pkg;

   localparam int unsigned WordSize = 16;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StRdReq = 3'd1,
      StRdRel = 3'd2,
      StWrReq = 3'd3,
      StWrRel = 3'd4,
      StErr   = 3'd5
   } mem_state_e;

   typedef enum logic {
      OwnIf = 1'b0,
      OwnD  = 1'b1
   } owner_e;

   // States in which the sequencer is waiting on a memory handshake edge.
   function automatic logic is_wait_state(mem_state_e s);
      return (s == StRdReq) || (s == StRdRel) || (s == StWrReq) || (s == StWrRel);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-side strobe/address/handshake bundle of the CPU's single memory port.
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = WordSize
) ();

   logic             readM;
   logic             writeM;
   logic [WIDTH-1:0] address;
   logic             inputReady;
   logic             ackOutput;

   modport master (
      output readM,
      output writeM,
      output address,
      input  inputReady,
      input  ackOutput
   );

   modport slave (
      input  readM,
      input  writeM,
      input  address,
      output inputReady,
      output ackOutput
   );

endinterface

// File: rtl/mem_handshake_fsm.sv
// Per-transfer strobe/handshake sequencer for one memory read or write.
// Optional watchdog abort when built with MEM_TIMEOUT_EN.
module mem_handshake_fsm
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned WORD_SIZE = WordSize
`ifdef MEM_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 we,
   input  logic [WORD_SIZE-1:0] addr,
   input  logic [WORD_SIZE-1:0] wdata,
   output logic                 idle,
   output logic                 done,
   output logic                 rd_capture,
   output logic [WORD_SIZE-1:0] rdata,
   output logic                 readM,
   output logic                 writeM,
   output logic [WORD_SIZE-1:0] address,
   output logic [WORD_SIZE-1:0] data_out,
   output logic                 data_oe,
   input  logic [WORD_SIZE-1:0] data_in,
   input  logic                 inputReady,
`ifdef MEM_TIMEOUT_EN
   input  logic                 ackOutput,
   output logic                 mem_err
`else
   input  logic                 ackOutput
`endif
);

   mem_state_e           state_q, state_d;
   logic [WORD_SIZE-1:0] addr_q, wdata_q;
   logic                 timeout;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         // Requester inputs are only sampled at grant.
         if (start && (state_q == StIdle)) begin
            addr_q  <= addr;
            wdata_q <= wdata;
         end
      end
   end

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            mem_err_q;

   // Counts cycles spent in the current wait state; restarts on every state change.
   always_comb begin
      cnt_d = cnt_q + CntW'(1);
      if ((state_d != state_q) || (state_q == StIdle)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         mem_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         mem_err_q <= mem_err_q | (state_d == StErr);
      end
   end

   assign timeout = is_wait_state(state_q) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
   assign mem_err = mem_err_q;
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      done       = 1'b0;
      rd_capture = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = we ? StWrReq : StRdReq;
            end
         end
         StRdReq: begin
            if (inputReady) begin
               rd_capture = 1'b1;
               state_d    = StRdRel;
            end else if (timeout) begin
               state_d = StErr;
            end
         end
         StRdRel: begin
            if (!inputReady) begin
               done    = 1'b1;
               state_d = StIdle;
            end else if (timeout) begin
               state_d = StErr;
            end
         end
         StWrReq: begin
            if (ackOutput) begin
               state_d = StWrRel;
            end else if (timeout) begin
               state_d = StErr;
            end
         end
         StWrRel: begin
            if (!ackOutput) begin
               done    = 1'b1;
               state_d = StIdle;
            end else if (timeout) begin
               state_d = StErr;
            end
         end
         StErr: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Strobes decode straight from the state register, so they are glitch-free and exclusive.
   assign idle     = (state_q == StIdle);
   assign readM    = (state_q == StRdReq);
   assign writeM   = (state_q == StWrReq);
   assign data_oe  = (state_q == StWrReq);
   assign data_out = wdata_q;
   assign address  = addr_q;
   assign rdata    = data_in;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store (data wins ties).
// Build with MEM_TIMEOUT_EN for the handshake watchdog and sticky mem_err output.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned WORD_SIZE = WordSize
`ifdef MEM_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 if_req,
   input  logic [WORD_SIZE-1:0] if_addr,
   output logic                 if_gnt,
   output logic                 if_done,
   output logic [WORD_SIZE-1:0] if_rdata,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [WORD_SIZE-1:0] d_addr,
   input  logic [WORD_SIZE-1:0] d_wdata,
   output logic                 d_gnt,
   output logic                 d_done,
   output logic [WORD_SIZE-1:0] d_rdata,
   mem_port_arbiter_if.master   mem,
`ifdef MEM_TIMEOUT_EN
   inout  wire  [WORD_SIZE-1:0] data,
   output logic                 mem_err
`else
   inout  wire  [WORD_SIZE-1:0] data
`endif
);

   owner_e               owner_q;
   logic [WORD_SIZE-1:0] if_rdata_q, d_rdata_q;
   logic                 start, fsm_idle, fsm_done, rd_capture, data_oe;
   logic [WORD_SIZE-1:0] req_addr, fsm_rdata, data_out;

   assign start    = fsm_idle && (d_req || if_req);
   assign req_addr = d_req ? d_addr : if_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q    <= OwnIf;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         if (start) begin
            owner_q <= d_req ? OwnD : OwnIf;
         end
         if (rd_capture) begin
            if (owner_q == OwnD) begin
               d_rdata_q <= fsm_rdata;
            end else begin
               if_rdata_q <= fsm_rdata;
            end
         end
      end
   end

   mem_handshake_fsm #(
`ifdef MEM_TIMEOUT_EN
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
`endif
      .WORD_SIZE      (WORD_SIZE)
   ) u_fsm (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .we         (d_req & d_we),
      .addr       (req_addr),
      .wdata      (d_wdata),
      .idle       (fsm_idle),
      .done       (fsm_done),
      .rd_capture (rd_capture),
      .rdata      (fsm_rdata),
      .readM      (mem.readM),
      .writeM     (mem.writeM),
      .address    (mem.address),
      .data_out   (data_out),
      .data_oe    (data_oe),
      .data_in    (data),
      .inputReady (mem.inputReady),
`ifdef MEM_TIMEOUT_EN
      .ackOutput  (mem.ackOutput),
      .mem_err    (mem_err)
`else
      .ackOutput  (mem.ackOutput)
`endif
   );

   assign data = data_oe ? data_out : {WORD_SIZE{1'bz}};

   assign if_gnt   = !fsm_idle && (owner_q == OwnIf);
   assign d_gnt    = !fsm_idle && (owner_q == OwnD);
   assign if_done  = fsm_done && (owner_q == OwnIf);
   assign d_done   = fsm_done && (owner_q == OwnD);
   assign if_rdata = if_rdata_q;
   assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a scoreboard of expected completions.
// Define MEM_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES = 8).
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic         if_req, d_req, d_we;
   logic [W-1:0] if_addr, d_addr, d_wdata;
   logic         if_gnt, if_done, d_gnt, d_done;
   logic [W-1:0] if_rdata, d_rdata;
`ifdef MEM_TIMEOUT_EN
   logic         mem_err;
`endif

   wire  [W-1:0] data;
   logic         drv;
   logic [W-1:0] drv_val;
   assign data = drv ? drv_val : {W{1'bz}};

   mem_port_arbiter_if #(.WIDTH(W)) mem_bus ();

   mem_port_arbiter #(
`ifdef MEM_TIMEOUT_EN
      .TIMEOUT_CYCLES (8),
`endif
      .WORD_SIZE      (W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_gnt   (if_gnt),
      .if_done  (if_done),
      .if_rdata (if_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_gnt    (d_gnt),
      .d_done   (d_done),
      .d_rdata  (d_rdata),
      .mem      (mem_bus),
`ifdef MEM_TIMEOUT_EN
      .data     (data),
      .mem_err  (mem_err)
`else
      .data     (data)
`endif
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic         is_d;
      logic         chk;
      logic [W-1:0] rdata;
   } exp_t;
   exp_t sb[$];

   int           rsp_delay = 1;
   bit           stuck = 1'b0;
   int           wr_hi = 0;
   logic [W-1:0] cur_wdata = '0;
   logic [W-1:0] mem_arr [256];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input bit is_d, input int budget, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(is_d ? d_done : if_done) && (lat < budget));
      check(is_d ? "d_done_in_budget" : "if_done_in_budget", is_d ? d_done : if_done, 1);
   endtask

   // Memory model: answers reads/writes rsp_delay cycles after the strobe, one-cycle handshake.
   initial begin
      int cnt;
      cnt = 0;
      for (int i = 0; i < 256; i++) mem_arr[i] = W'(i * 16'h0101);
      mem_arr[8'h10] = 16'h6A05;
      mem_arr[8'h20] = 16'h1234;
      mem_arr[8'h22] = 16'h5A5A;
      mem_arr[8'h40] = 16'hABCD;
      drv = 1'b0;
      drv_val = '0;
      mem_bus.inputReady = 1'b0;
      mem_bus.ackOutput = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            mem_bus.inputReady = 1'b0;
            mem_bus.ackOutput = 1'b0;
            drv = 1'b0;
            cnt = 0;
         end else begin
            if (mem_bus.inputReady) begin
               mem_bus.inputReady = 1'b0;
               drv = 1'b0;
            end else if (mem_bus.readM && !stuck) begin
               if (cnt == rsp_delay) begin
                  mem_bus.inputReady = 1'b1;
                  drv_val = mem_arr[mem_bus.address[7:0]];
                  drv = 1'b1;
                  cnt = 0;
               end else cnt++;
            end
            if (mem_bus.ackOutput) begin
               mem_bus.ackOutput = 1'b0;
            end else if (mem_bus.writeM && !stuck) begin
               if (cnt == rsp_delay) begin
                  mem_bus.ackOutput = 1'b1;
                  mem_arr[mem_bus.address[7:0]] = data;
                  cnt = 0;
               end else cnt++;
            end
            if (!mem_bus.readM && !mem_bus.writeM) cnt = 0;
         end
      end
   end

   // Per-cycle invariants and scoreboard pop on every completion pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            check("strobe_exclusive", mem_bus.readM & mem_bus.writeM, 0);
            check("gnt_onehot", if_gnt & d_gnt, 0);
            check("done_implies_gnt", (if_done & ~if_gnt) | (d_done & ~d_gnt), 0);
            if (mem_bus.writeM) begin
               check("wdata_on_bus", data, cur_wdata);
               wr_hi++;
            end
            if (if_done || d_done) begin
               check("done_was_expected", sb.size() != 0, 1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  check("done_owner_is_d", d_done, e.is_d);
                  check("single_done", if_done & d_done, 0);
                  if (e.chk) check(e.is_d ? "d_rdata" : "if_rdata",
                                   e.is_d ? d_rdata : if_rdata, e.rdata);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      reset = 1'b1;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_readM", mem_bus.readM, 0);
      check("rst_writeM", mem_bus.writeM, 0);
      check("rst_address", mem_bus.address, 0);
      check("rst_gnts", {if_gnt, d_gnt}, 0);
      check("rst_dones", {if_done, d_done}, 0);
      check("rst_rdata", {if_rdata, d_rdata}, 0);
`ifdef MEM_TIMEOUT_EN
      check("rst_mem_err", mem_err, 0);
`endif
      reset = 1'b0;
      @(negedge clk);

      // Fetch only, minimum latency.
      rsp_delay = 1;
      if_addr = 16'h0010; if_req = 1'b1;
      sb.push_back('{is_d: 1'b0, chk: 1'b1, rdata: 16'h6A05});
      @(negedge clk);
      check("f_c1_readM", mem_bus.readM, 1);
      check("f_c1_if_gnt", if_gnt, 1);
      check("f_c1_d_gnt", d_gnt, 0);
      check("f_c1_address", mem_bus.address, 16'h0010);
      @(negedge clk);
      check("f_c2_readM", mem_bus.readM, 1);
      check("f_c2_if_done", if_done, 0);
      @(negedge clk);
      check("f_c3_readM", mem_bus.readM, 0);
      check("f_c3_if_done", if_done, 1);
      check("f_c3_if_rdata", if_rdata, 16'h6A05);
      if_req = 1'b0;
      @(negedge clk);
      check("f_c4_if_gnt", if_gnt, 0);

      // Simultaneous requests: data wins, fetch follows after one idle cycle.
      d_we = 1'b0; d_addr = 16'h0020; d_req = 1'b1;
      if_addr = 16'h0040; if_req = 1'b1;
      sb.push_back('{is_d: 1'b1, chk: 1'b1, rdata: 16'h1234});
      sb.push_back('{is_d: 1'b0, chk: 1'b1, rdata: 16'hABCD});
      @(negedge clk);
      check("s_d_gnt_first", d_gnt, 1);
      check("s_if_waits", if_gnt, 0);
      check("s_address_d", mem_bus.address, 16'h0020);
      wait_done(1'b1, 20, lat);
      check("s_load_latency", lat, 2);
      d_req = 1'b0;
      @(negedge clk);
      check("s_idle_gnts", {if_gnt, d_gnt}, 0);
      @(negedge clk);
      check("s_if_gnt", if_gnt, 1);
      check("s_address_if", mem_bus.address, 16'h0040);
      wait_done(1'b0, 20, lat);
      if_req = 1'b0;
      check("s_d_rdata_held", d_rdata, 16'h1234);

      // Store with slow acknowledge.
      @(negedge clk);
      rsp_delay = 4; wr_hi = 0; cur_wdata = 16'hBEEF;
      d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'hBEEF; d_req = 1'b1;
      sb.push_back('{is_d: 1'b1, chk: 1'b0, rdata: '0});
      wait_done(1'b1, 30, lat);
      d_req = 1'b0; d_we = 1'b0;
      check("w_latency", lat, 6);
      check("w_writeM_low", mem_bus.writeM, 0);
      check("w_strobe_cycles", wr_hi, 5);
      check("w_data_released", data !== 16'hBEEF, 1);
      @(negedge clk);
      check("w_mem_written", mem_arr[8'h30], 16'hBEEF);
      check("w_d_rdata_held", d_rdata, 16'h1234);
      check("w_if_rdata_held", if_rdata, 16'hABCD);

      // Requester drops d_req mid-load; transfer still completes.
      rsp_delay = 2;
      d_addr = 16'h0022; d_req = 1'b1;
      sb.push_back('{is_d: 1'b1, chk: 1'b1, rdata: 16'h5A5A});
      @(negedge clk);
      d_req = 1'b0;
      wait_done(1'b1, 20, lat);
      check("drop_latency", lat, 3);

      // Reset in RD_REQ aborts without a done pulse.
      @(negedge clk);
      rsp_delay = 10;
      if_addr = 16'h0050; if_req = 1'b1;
      @(negedge clk);
      check("r_if_gnt", if_gnt, 1);
      @(negedge clk);
      check("r_readM_before", mem_bus.readM, 1);
      reset = 1'b1; if_req = 1'b0;
      @(negedge clk);
      check("r_readM_after", mem_bus.readM, 0);
      check("r_gnts_after", {if_gnt, d_gnt}, 0);
      check("r_no_done", {if_done, d_done}, 0);
      check("r_if_rdata_cleared", if_rdata, 0);
      reset = 1'b0;
      @(negedge clk);
      rsp_delay = 1;
      if_addr = 16'h0010; if_req = 1'b1;
      sb.push_back('{is_d: 1'b0, chk: 1'b1, rdata: 16'h6A05});
      wait_done(1'b0, 20, lat);
      if_req = 1'b0;
      check("r_refetch_latency", lat, 3);

`ifdef MEM_TIMEOUT_EN
      // Stuck memory: watchdog aborts, mem_err stays set afterwards.
      @(negedge clk);
      stuck = 1'b1;
      if_addr = 16'h0060; if_req = 1'b1;
      sb.push_back('{is_d: 1'b0, chk: 1'b1, rdata: 16'h6A05});
      wait_done(1'b0, 30, lat);
      if_req = 1'b0;
      check("t_latency", lat, 9);
      check("t_readM_dropped", mem_bus.readM, 0);
      check("t_mem_err_set", mem_err, 1);
      stuck = 1'b0;
      @(negedge clk);
      d_we = 1'b0; d_addr = 16'h0020; d_req = 1'b1;
      sb.push_back('{is_d: 1'b1, chk: 1'b1, rdata: 16'h1234});
      wait_done(1'b1, 20, lat);
      d_req = 1'b0;
      check("t_good_latency", lat, 3);
      check("t_mem_err_sticky", mem_err, 1);
`endif

      repeat (3) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
